riscv_decode_stage: RTL and testbench
=====================================

// Module: riscv_decode_stage
// PURPOSE
//  ID pipeline stage between fetch and execute. Accepts {instr, pc} from IF over valid/ready
//  and drives register-file read addresses. Decodes fields and the immediate, then registers a
//  riscv_pkg::decoded_instr_t towards EX over valid/ready. Also owns load-use bubble insertion,
//  WB->ID write bypass and flush.
// PARAMETERS
//  XLEN        32   register/data width
//  RESET_PC    0    pc field value held in the output register at reset
// PORTS
//  clk           in   1     clock
//  rst_n         in   1     asynchronous active-low reset
//  if_valid      in   1     IF holds a valid instruction
//  if_ready      out  1     ID accepts this cycle
//  if_instr      in   32    raw instruction
//  if_pc         in   XLEN  PC of if_instr
//  rf_rs1_addr   out  5     = if_instr[19:15], combinational
//  rf_rs2_addr   out  5     = if_instr[24:20], combinational
//  rf_rs1_data   in   XLEN  combinational read data, port 1
//  rf_rs2_data   in   XLEN  combinational read data, port 2
//  wb_we         in   1     writeback write enable
//  wb_rd         in   5     writeback destination
//  wb_data       in   XLEN  writeback data
//  flush         in   1     EX redirect; kill ID contents
//  id_valid      out  1     output register holds a valid instruction
//  id_ready      in   1     EX accepts
//  id_instr      out  $bits(decoded_instr_t)  registered decoded instruction
//  id_illegal    out  1     registered illegal-instruction flag
// BEHAVIOUR
//  Reset: id_valid=0, id_instr=0 except pc=RESET_PC, id_illegal=0. Output is fully registered; latency IF accept -> id_valid = 1 cycle.
//  Handshakes:
//   - out_fire = id_valid & id_ready; in_fire = if_valid & if_ready.
//   - if_ready = (!id_valid | id_ready) & !lu_hazard & !flush.
//  Load-use hazard: lu_hazard = id_valid & id_instr.opcode==OPCODE_LOAD & id_instr.rd!=0 & if_valid
//   & (rd==rs1 | rd==rs2 of if_instr, rs2 considered only for R/S/B types).
//   Effect: on out_fire with hazard, id_valid->0 (one-cycle bubble); the instruction is taken next cycle.
//  Update priority:
//   1. flush: id_valid<=0, input ignored.
//   2. in_fire: load decoded instr, id_valid<=1.
//   3. out_fire: id_valid<=0.
//   4. otherwise hold all outputs stable while id_valid & !id_ready.
//  Operands: reg_A/reg_B = 0 if rs==x0; else wb_data if wb_we & wb_rd==rs; else rf data.
//  Immediates: XLEN sign-extended.
//   - I: instr[31:20]
//   - S: {instr[31:25],instr[11:7]}
//   - B: {instr[31],instr[7],instr[30:25],instr[11:8],0}
//   - U: {instr[31:12],12'b0}
//   - J: {instr[31],instr[19:12],instr[20],instr[30:21],0}
//   - R-type: imm = 0
//  Illegal: opcode not in opcode_t; JALR f3!=0; BRANCH f3 in {010,011}; LOAD f3 in {011,110,111};
//   STORE f3>010; REG_REG f7 not 0/0x20, or f7=0x20 with f3 not 000/101;
//   REG_IMM f3=001 with f7!=0; REG_IMM f3=101 with f7 not 0/0x20; low two bits !=11.
//  Reset mid-transfer: the in-flight instruction is dropped; IF re-presents it after reset.
// CONFIGURATION
//  RISCV_DECODE_ILLEGAL_TRAP_EN defined: illegal instr passed through unchanged, id_illegal=1 alongside it.
//  Not defined: illegal instr replaced by NOP (addi x0,x0,0, same pc); id_illegal tied 0.
// STRUCTURE
//  riscv_pkg additions:
//   - decoded_instr_t.imm widened to [XLEN-1:0]
//   - imm_sel_t enum {IMM_I,IMM_S,IMM_B,IMM_U,IMM_J,IMM_NONE}
//   - funct7 values as localparams (0x00/0x20), since the duplicate-valued enum is illegal
//   - NOP_INSTR=32'h00000013
//   - XLEN/DATA_WIDTH as package parameters
//  Sub-module: riscv_imm_gen (combinational; instr, imm_sel -> imm).
// TESTING
//  1. 0x00500093 (addi x1,x0,5) -> id_valid next cycle, rd=1, rs1=0, reg_A=0, imm=5, id_illegal=0.
//  2. 0x0000A103 (lw x2,0(x1)) then 0x001101B3 (add x3,x2,x1), id_ready=1
//     -> lw out, one bubble cycle (if_ready=0, id_valid=0), add next; add's reg_A taken from wb bypass when wb_rd=2.
//  3. 0x123452B7 (lui x5,0x12345) -> imm=0x12345000; 0xFFF00093 -> imm=0xFFFFFFFF.
//  4. id_ready=0 for 3 cycles with id_valid=1 -> id_instr stable, if_ready=0; id_ready=1 -> next instr loaded same edge.
//  5. flush=1 while id_valid=1 and if_valid=1 -> id_valid=0 next cycle, the IF instruction is not captured.
//  6. 0xFFFFFFFF -> id_illegal=1 with RISCV_DECODE_ILLEGAL_TRAP_EN, else decoded as NOP (opcode 0x13, rd=0).

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 decode types: opcodes, immediate selectors, funct7 values and the ID->EX record.
package riscv_pkg;

    parameter int unsigned XLEN       = 32;
    parameter int unsigned DATA_WIDTH = XLEN;

    typedef enum logic [6:0] {
        OPCODE_LOAD     = 7'h03,
        OPCODE_MISC_MEM = 7'h0F,
        OPCODE_REG_IMM  = 7'h13,
        OPCODE_AUIPC    = 7'h17,
        OPCODE_STORE    = 7'h23,
        OPCODE_REG_REG  = 7'h33,
        OPCODE_LUI      = 7'h37,
        OPCODE_BRANCH   = 7'h63,
        OPCODE_JALR     = 7'h67,
        OPCODE_JAL      = 7'h6F,
        OPCODE_SYSTEM   = 7'h73
    } opcode_t;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_sel_t;

    // Two funct7 encodings share a value across instructions, so they cannot be one enum.
    localparam logic [6:0] FUNCT7_BASE = 7'h00;
    localparam logic [6:0] FUNCT7_ALT  = 7'h20;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] reg_a;
        logic [XLEN-1:0] reg_b;
    } decoded_instr_t;

    function automatic imm_sel_t imm_sel_of(input logic [6:0] opcode);
        imm_sel_t sel;
        case (opcode)
            OPCODE_STORE:              sel = IMM_S;
            OPCODE_BRANCH:             sel = IMM_B;
            OPCODE_LUI, OPCODE_AUIPC:  sel = IMM_U;
            OPCODE_JAL:                sel = IMM_J;
            OPCODE_REG_REG:            sel = IMM_NONE;
            default:                   sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational immediate generator: selects and sign-extends the RV32 immediate formats.
module riscv_imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0]     i_instr,
    input  imm_sel_t        i_imm_sel,
    output logic [XLEN-1:0] o_imm
);

    logic [31:0] w_imm32;

    always_comb begin
        w_imm32 = '0;
        case (i_imm_sel)
            IMM_I:    w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S:    w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:    w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                                 i_instr[11:8], 1'b0};
            IMM_U:    w_imm32 = {i_instr[31:12], 12'b0};
            IMM_J:    w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                                 i_instr[30:21], 1'b0};
            default:  w_imm32 = '0;
        endcase
    end

    assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/riscv_decode_stage.sv
// ID stage: decode, operand read with WB bypass, load-use bubble, flush, registered output.
// Define RISCV_DECODE_ILLEGAL_TRAP_EN to pass illegal instructions through with o_id_illegal.
module riscv_decode_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_if_valid,
    output logic            o_if_ready,
    input  logic [31:0]     i_if_instr,
    input  logic [XLEN-1:0] i_if_pc,
    output logic [4:0]      o_rf_rs1_addr,
    output logic [4:0]      o_rf_rs2_addr,
    input  logic [XLEN-1:0] i_rf_rs1_data,
    input  logic [XLEN-1:0] i_rf_rs2_data,
    input  logic            i_wb_we,
    input  logic [4:0]      i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    input  logic            i_flush,
    output logic            o_id_valid,
    input  logic            i_id_ready,
    output decoded_instr_t  o_id_instr,
    output logic            o_id_illegal
);

    logic           r_id_valid;
    decoded_instr_t r_id_instr;
    decoded_instr_t w_dec;
    logic [31:0]    w_instr;
    logic [XLEN-1:0] w_imm;
    logic           w_illegal;
    logic           w_lu_hazard;
    logic           w_in_fire;
    logic           w_out_fire;
    logic           w_uses_rs2;

    wire [6:0] w_op = i_if_instr[6:0];
    wire [2:0] w_f3 = i_if_instr[14:12];
    wire [6:0] w_f7 = i_if_instr[31:25];

    assign o_rf_rs1_addr = i_if_instr[19:15];
    assign o_rf_rs2_addr = i_if_instr[24:20];

    always_comb begin
        w_illegal = (i_if_instr[1:0] != 2'b11);
        case (w_op)
            OPCODE_LOAD:     if (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111)
                                 w_illegal = 1'b1;
            OPCODE_STORE:    if (w_f3 > 3'b010) w_illegal = 1'b1;
            OPCODE_BRANCH:   if (w_f3 == 3'b010 || w_f3 == 3'b011) w_illegal = 1'b1;
            OPCODE_JALR:     if (w_f3 != 3'b000) w_illegal = 1'b1;
            OPCODE_REG_REG: begin
                if (w_f7 != FUNCT7_BASE && w_f7 != FUNCT7_ALT) w_illegal = 1'b1;
                if (w_f7 == FUNCT7_ALT && w_f3 != 3'b000 && w_f3 != 3'b101) w_illegal = 1'b1;
            end
            OPCODE_REG_IMM: begin
                if (w_f3 == 3'b001 && w_f7 != FUNCT7_BASE) w_illegal = 1'b1;
                if (w_f3 == 3'b101 && w_f7 != FUNCT7_BASE && w_f7 != FUNCT7_ALT)
                    w_illegal = 1'b1;
            end
            OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_MISC_MEM, OPCODE_SYSTEM: ;
            default:         w_illegal = 1'b1;
        endcase
    end

`ifdef RISCV_DECODE_ILLEGAL_TRAP_EN
    assign w_instr = i_if_instr;
`else
    assign w_instr = w_illegal ? NOP_INSTR : i_if_instr;
`endif

    riscv_imm_gen u_imm_gen (
        .i_instr   (w_instr),
        .i_imm_sel (imm_sel_of(w_instr[6:0])),
        .o_imm     (w_imm)
    );

    // Operands: x0 reads zero, a same-cycle WB write wins over the RF read port.
    always_comb begin
        w_dec        = '0;
        w_dec.pc     = i_if_pc;
        w_dec.opcode = w_instr[6:0];
        w_dec.rd     = w_instr[11:7];
        w_dec.funct3 = w_instr[14:12];
        w_dec.rs1    = w_instr[19:15];
        w_dec.rs2    = w_instr[24:20];
        w_dec.funct7 = w_instr[31:25];
        w_dec.imm    = w_imm;
        if (w_dec.rs1 == 5'd0)                      w_dec.reg_a = '0;
        else if (i_wb_we && i_wb_rd == w_dec.rs1)   w_dec.reg_a = i_wb_data;
        else                                        w_dec.reg_a = i_rf_rs1_data;
        if (w_dec.rs2 == 5'd0)                      w_dec.reg_b = '0;
        else if (i_wb_we && i_wb_rd == w_dec.rs2)   w_dec.reg_b = i_wb_data;
        else                                        w_dec.reg_b = i_rf_rs2_data;
    end

    assign w_uses_rs2 = (w_op == OPCODE_REG_REG) || (w_op == OPCODE_STORE) ||
                        (w_op == OPCODE_BRANCH);

    assign w_lu_hazard = r_id_valid && (r_id_instr.opcode == OPCODE_LOAD) &&
                         (r_id_instr.rd != 5'd0) && i_if_valid &&
                         ((r_id_instr.rd == i_if_instr[19:15]) ||
                          (w_uses_rs2 && r_id_instr.rd == i_if_instr[24:20]));

    assign o_if_ready = (!r_id_valid || i_id_ready) && !w_lu_hazard && !i_flush;
    assign w_in_fire  = i_if_valid && o_if_ready;
    assign w_out_fire = r_id_valid && i_id_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_id_valid    <= 1'b0;
            r_id_instr    <= '0;
            r_id_instr.pc <= RESET_PC;
        end else if (i_flush) begin
            r_id_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_id_valid <= 1'b1;
            r_id_instr <= w_dec;
        end else if (w_out_fire) begin
            r_id_valid <= 1'b0;
        end
    end

`ifdef RISCV_DECODE_ILLEGAL_TRAP_EN
    logic r_id_illegal;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)           r_id_illegal <= 1'b0;
        else if (i_flush)       r_id_illegal <= r_id_illegal;
        else if (w_in_fire)     r_id_illegal <= w_illegal;
    end

    assign o_id_illegal = r_id_illegal;
`else
    assign o_id_illegal = 1'b0;
`endif

    assign o_id_valid = r_id_valid;
    assign o_id_instr = r_id_instr;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Directed bench for riscv_decode_stage: decode, bypass, load-use bubble, stall, flush, illegal.
module tb_riscv_decode_stage;
    import riscv_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0080;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           if_valid;
    logic           if_ready;
    logic [31:0]    if_instr;
    logic [31:0]    if_pc;
    logic [4:0]     rs1_addr;
    logic [4:0]     rs2_addr;
    logic [31:0]    rs1_data;
    logic [31:0]    rs2_data;
    logic           wb_we;
    logic [4:0]     wb_rd;
    logic [31:0]    wb_data;
    logic           flush;
    logic           id_valid;
    logic           id_ready;
    decoded_instr_t id_instr;
    logic           id_illegal;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Register file model: distinct, address-derived contents per read port.
    assign rs1_data = 32'h0000_1000 + {27'b0, rs1_addr};
    assign rs2_data = 32'h0000_2000 + {27'b0, rs2_addr};

    riscv_decode_stage #(.RESET_PC(TB_RESET_PC)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_if_valid    (if_valid),
        .o_if_ready    (if_ready),
        .i_if_instr    (if_instr),
        .i_if_pc       (if_pc),
        .o_rf_rs1_addr (rs1_addr),
        .o_rf_rs2_addr (rs2_addr),
        .i_rf_rs1_data (rs1_data),
        .i_rf_rs2_data (rs2_data),
        .i_wb_we       (wb_we),
        .i_wb_rd       (wb_rd),
        .i_wb_data     (wb_data),
        .i_flush       (flush),
        .o_id_valid    (id_valid),
        .i_id_ready    (id_ready),
        .o_id_instr    (id_instr),
        .o_id_illegal  (id_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
        #1;
    endtask

    decoded_instr_t exp_rst;

    initial begin
        rst_n    = 1'b0;
        if_valid = 1'b0;
        if_instr = 32'h0;
        if_pc    = 32'h0;
        wb_we    = 1'b0;
        wb_rd    = 5'd0;
        wb_data  = 32'h0;
        flush    = 1'b0;
        id_ready = 1'b0;
        #12;
        exp_rst    = '0;
        exp_rst.pc = TB_RESET_PC;
        chk("rst_valid", {63'b0, id_valid}, 64'd0);
        chk("rst_instr", {40'b0, id_instr.pc}, {40'b0, exp_rst.pc});
        chk("rst_whole", 64'(id_instr === exp_rst), 64'd1);
        chk("rst_illegal", {63'b0, id_illegal}, 64'd0);
        rst_n = 1'b1;
        step();
        chk("idle_if_ready", {63'b0, if_ready}, 64'd1);

        // addi x1,x0,5
        present(32'h00500093, 32'h100);
        chk("t1_rs1_addr", {59'b0, rs1_addr}, 64'd0);
        chk("t1_rs2_addr", {59'b0, rs2_addr}, 64'd5);
        step();
        chk("t1_valid", {63'b0, id_valid}, 64'd1);
        chk("t1_rd", {59'b0, id_instr.rd}, 64'd1);
        chk("t1_rs1", {59'b0, id_instr.rs1}, 64'd0);
        chk("t1_reg_a", {32'b0, id_instr.reg_a}, 64'd0);
        chk("t1_imm", {32'b0, id_instr.imm}, 64'd5);
        chk("t1_pc", {32'b0, id_instr.pc}, 64'h100);
        chk("t1_illegal", {63'b0, id_illegal}, 64'd0);
        if_valid = 1'b0;
        id_ready = 1'b1;
        step();
        chk("t1_drain", {63'b0, id_valid}, 64'd0);

        // lw x2,0(x1) then dependent add x3,x2,x1
        present(32'h0000A103, 32'h104);
        step();
        chk("t2_lw_valid", {63'b0, id_valid}, 64'd1);
        chk("t2_lw_op", {57'b0, id_instr.opcode}, 64'h03);
        chk("t2_lw_reg_a", {32'b0, id_instr.reg_a}, 64'h1001);
        present(32'h001101B3, 32'h108);
        chk("t2_hazard_ready", {63'b0, if_ready}, 64'd0);
        step();
        chk("t2_bubble_valid", {63'b0, id_valid}, 64'd0);
        chk("t2_bubble_ready", {63'b0, if_ready}, 64'd1);
        wb_we   = 1'b1;
        wb_rd   = 5'd2;
        wb_data = 32'hDEAD_BEEF;
        step();
        chk("t2_add_valid", {63'b0, id_valid}, 64'd1);
        chk("t2_add_rd", {59'b0, id_instr.rd}, 64'd3);
        chk("t2_add_pc", {32'b0, id_instr.pc}, 64'h108);
        chk("t2_add_reg_a", {32'b0, id_instr.reg_a}, 64'hDEAD_BEEF);
        chk("t2_add_reg_b", {32'b0, id_instr.reg_b}, 64'h2001);
        chk("t2_add_imm", {32'b0, id_instr.imm}, 64'd0);
        wb_we = 1'b0;

        // Immediate formats, streamed back to back
        present(32'h123452B7, 32'h110);
        step();
        chk("t3_lui_imm", {32'b0, id_instr.imm}, 64'h1234_5000);
        chk("t3_lui_rd", {59'b0, id_instr.rd}, 64'd5);
        present(32'hFFF00093, 32'h114);
        step();
        chk("t3_addi_neg_imm", {32'b0, id_instr.imm}, 64'hFFFF_FFFF);
        present(32'hFE20AE23, 32'h118);
        step();
        chk("t3_sw_imm", {32'b0, id_instr.imm}, 64'hFFFF_FFFC);
        chk("t3_sw_reg_b", {32'b0, id_instr.reg_b}, 64'h2002);
        present(32'h00208863, 32'h11C);
        step();
        chk("t3_beq_imm", {32'b0, id_instr.imm}, 64'd16);
        present(32'h008000EF, 32'h120);
        step();
        chk("t3_jal_imm", {32'b0, id_instr.imm}, 64'd8);
        chk("t3_jal_rd", {59'b0, id_instr.rd}, 64'd1);
        if_valid = 1'b0;
        step();
        chk("t3_drain", {63'b0, id_valid}, 64'd0);

        // Back-pressure: hold for three cycles, then load next on the release edge
        id_ready = 1'b0;
        present(32'h00500093, 32'h200);
        step();
        present(32'h00700113, 32'h204);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_hold_valid", {63'b0, id_valid}, 64'd1);
            chk("t4_hold_pc", {32'b0, id_instr.pc}, 64'h200);
            chk("t4_hold_imm", {32'b0, id_instr.imm}, 64'd5);
            chk("t4_hold_if_ready", {63'b0, if_ready}, 64'd0);
        end
        id_ready = 1'b1;
        #1;
        chk("t4_release_ready", {63'b0, if_ready}, 64'd1);
        step();
        chk("t4_next_pc", {32'b0, id_instr.pc}, 64'h204);
        chk("t4_next_imm", {32'b0, id_instr.imm}, 64'd7);
        chk("t4_next_rd", {59'b0, id_instr.rd}, 64'd2);
        if_valid = 1'b0;
        step();

        // Flush while occupied with a pending IF instruction
        id_ready = 1'b0;
        present(32'h00500093, 32'h300);
        step();
        chk("t5_loaded", {63'b0, id_valid}, 64'd1);
        present(32'h00700113, 32'h304);
        flush = 1'b1;
        #1;
        chk("t5_flush_ready", {63'b0, if_ready}, 64'd0);
        step();
        chk("t5_flushed", {63'b0, id_valid}, 64'd0);
        flush    = 1'b0;
        if_valid = 1'b0;
        step();
        chk("t5_not_captured", {63'b0, id_valid}, 64'd0);

        // Illegal encoding
        id_ready = 1'b1;
        present(32'hFFFFFFFF, 32'h400);
        step();
        chk("t6_valid", {63'b0, id_valid}, 64'd1);
        chk("t6_pc", {32'b0, id_instr.pc}, 64'h400);
`ifdef RISCV_DECODE_ILLEGAL_TRAP_EN
        chk("t6_illegal", {63'b0, id_illegal}, 64'd1);
        chk("t6_opcode", {57'b0, id_instr.opcode}, 64'h7F);
`else
        chk("t6_illegal", {63'b0, id_illegal}, 64'd0);
        chk("t6_opcode", {57'b0, id_instr.opcode}, 64'h13);
        chk("t6_rd", {59'b0, id_instr.rd}, 64'd0);
        chk("t6_imm", {32'b0, id_instr.imm}, 64'd0);
`endif
        if_valid = 1'b0;
        step();
        chk("t6_drain", {63'b0, id_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
